// File: rtl/key_display_scheduler_if.sv
// key_display_scheduler_if: scan-code input and multiplexed digit-bus output bundle.
interface key_display_scheduler_if;
    logic       i_sc_valid;
    logic [7:0] i_sc;
    logic       i_clear;
    logic [3:0] o_digit;
    logic       o_blank;
    logic [3:0] o_seg_en;
    logic [2:0] o_key_count;
    modport slave (input i_sc_valid, i_sc, i_clear, output o_digit, o_blank, o_seg_en, o_key_count);
    modport master (output i_sc_valid, i_sc, i_clear, input o_digit, o_blank, o_seg_en, o_key_count);
endinterface

// File: rtl/key_display_scheduler.sv
// key_display_scheduler: PS/2 make-code filter, 4-key BCD buffer and digit-bus multiplexer.
// Define KEY_DISP_BLANK_EN to drive empty slots dark.
module key_display_scheduler #(
    parameter int         REFRESH_DIV = 50000,
    parameter logic [7:0] BREAK_CODE  = 8'hF0,
    parameter logic [7:0] EXT_CODE    = 8'hE0
) (
    input logic clk,
    input logic rst,
    key_display_scheduler_if.slave bus
);
    localparam int CW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
    typedef enum logic {IDLE, BREAK} state_t;
    state_t r_state, w_state_next;
    logic w_push, w_tc;
    logic [3:0] w_code;
    logic [3:0] r_slot [4];
    logic [2:0] r_count;
    logic [CW-1:0] r_cnt;
    logic r_tc;
    logic [1:0] r_idx;
    logic [3:0] r_digit, r_seg_en;
    logic r_blank;
    always_comb begin
        w_state_next = r_state;
        w_push = 1'b0;
        if (bus.i_sc_valid && !bus.i_clear) begin
            if (r_state == BREAK) w_state_next = IDLE;
            else if (bus.i_sc == BREAK_CODE) w_state_next = BREAK;
            else w_push = bus.i_sc != EXT_CODE;
        end
    end
    always_comb begin
        w_code = 4'hE;
        case (bus.i_sc)
            8'h45: w_code = 4'd0;
            8'h16: w_code = 4'd1;
            8'h1E: w_code = 4'd2;
            8'h26: w_code = 4'd3;
            8'h25: w_code = 4'd4;
            8'h2E: w_code = 4'd5;
            8'h36: w_code = 4'd6;
            8'h3D: w_code = 4'd7;
            8'h3E: w_code = 4'd8;
            8'h46: w_code = 4'd9;
            default: w_code = 4'hE;
        endcase
    end
    assign w_tc = r_cnt == CW'(REFRESH_DIV - 1);
    always_ff @(posedge clk) begin
        if (!rst) r_state <= IDLE;
        else r_state <= w_state_next;
    end
    // Valid slots are always a contiguous run from slot 0, so key_count doubles as the valid mask.
    always_ff @(posedge clk) begin
        if (!rst || bus.i_clear) begin
            for (int i = 0; i < 4; i++) r_slot[i] <= 4'd0;
            r_count <= 3'd0;
        end else if (w_push) begin
            r_slot[0] <= w_code;
            for (int i = 1; i < 4; i++) r_slot[i] <= r_slot[i-1];
            r_count <= r_count == 3'd4 ? 3'd4 : r_count + 3'd1;
        end
    end
    // The terminal count is registered, so the digit outputs move one cycle after the wrap.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
            r_tc <= 1'b0;
            r_idx <= 2'd0;
            r_seg_en <= 4'b1111;
            r_digit <= 4'd0;
            r_blank <= 1'b0;
        end else begin
            r_cnt <= w_tc ? '0 : r_cnt + CW'(1);
            r_tc <= w_tc;
            if (r_tc) begin
                r_idx <= r_idx + 2'd1;
                r_seg_en <= ~(4'b0001 << r_idx);
                r_digit <= r_slot[r_idx];
`ifdef KEY_DISP_BLANK_EN
                r_blank <= r_count <= {1'b0, r_idx};
`else
                r_blank <= 1'b0;
`endif
            end
        end
    end
    assign bus.o_digit = r_digit;
    assign bus.o_blank = r_blank;
    assign bus.o_seg_en = r_seg_en;
    assign bus.o_key_count = r_count;
endmodule
